// File: rtl/piece_spawner.sv
// piece_spawner: pops the next-piece queue into the active falling piece
// and manages the hold slot with its one-hold-per-piece lockout.
module piece_spawner #(
  parameter bit HOLD_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       clear,
  input  logic       spawn_req,
  input  logic       hold_req,
  input  logic [3:0] queue_front,
  output logic       pieces_remove,
  output logic [3:0] active_type,
  output logic       active_valid,
  output logic [3:0] hold_type,
  output logic       hold_used,
  output logic       spawn_done
);

  localparam int unsigned TILE_W = 4;
  localparam logic [TILE_W-1:0] BLANK = TILE_W'(0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_POP    = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] active_type_q, active_type_d;
  logic [TILE_W-1:0] hold_type_q, hold_type_d;
  logic              hold_used_q, hold_used_d;
  logic              pieces_remove_q, pieces_remove_d;
  logic              active_valid_q, active_valid_d;
  logic              spawn_done_q, spawn_done_d;
  logic              hold_go;

  // A hold is honoured only when enabled and not yet used for this piece.
  assign hold_go = HOLD_ENABLE && hold_req && !hold_used_q;

  // Next-state and next-output logic; clear dominates every state.
  always_comb begin
    state_d         = state_q;
    active_type_d   = active_type_q;
    hold_type_d     = hold_type_q;
    hold_used_d     = hold_used_q;
    pieces_remove_d = 1'b0;
    spawn_done_d    = 1'b0;

    if (clear) begin
      state_d       = S_IDLE;
      active_type_d = BLANK;
      hold_type_d   = BLANK;
      hold_used_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spawn_req) begin
            state_d     = S_FETCH;
            hold_used_d = 1'b0;
          end
        end
        S_FETCH: begin
          // Capture here; the pop happens next cycle so the head shifts after capture.
          if (queue_front != BLANK) begin
            active_type_d   = queue_front;
            state_d         = S_POP;
            pieces_remove_d = 1'b1;
          end
        end
        S_POP: begin
          state_d      = S_ACTIVE;
          spawn_done_d = 1'b1;
        end
        S_ACTIVE: begin
          if (spawn_req) begin
            state_d     = S_FETCH;
            hold_used_d = 1'b0;
          end else if (hold_go) begin
            hold_used_d = 1'b1;
            if (hold_type_q == BLANK) begin
              // Empty slot: stash the piece and fetch a fresh one from the queue.
              hold_type_d = active_type_q;
              state_d     = S_FETCH;
            end else begin
              // Occupied slot: swap in place, no queue traffic.
              hold_type_d   = active_type_q;
              active_type_d = hold_type_q;
              spawn_done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    active_valid_d = (state_d == S_ACTIVE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q         <= S_IDLE;
      active_type_q   <= BLANK;
      hold_type_q     <= BLANK;
      hold_used_q     <= 1'b0;
      pieces_remove_q <= 1'b0;
      active_valid_q  <= 1'b0;
      spawn_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_type_q   <= active_type_d;
      hold_type_q     <= hold_type_d;
      hold_used_q     <= hold_used_d;
      pieces_remove_q <= pieces_remove_d;
      active_valid_q  <= active_valid_d;
      spawn_done_q    <= spawn_done_d;
    end
  end

  assign pieces_remove = pieces_remove_q;
  assign active_type   = active_type_q;
  assign active_valid  = active_valid_q;
  assign hold_type     = hold_type_q;
  assign hold_used     = hold_used_q;
  assign spawn_done    = spawn_done_q;

endmodule

// File: tb/tb_piece_spawner.sv
// Bench for piece_spawner: directed scenarios with literal expectations plus
// random traffic, both checked every cycle against a behavioural model.
module tb_piece_spawner;

  localparam logic [3:0] T_BLANK = 4'd0;
  localparam logic [3:0] T_I = 4'd1;
  localparam logic [3:0] T_O = 4'd2;
  localparam logic [3:0] T_T = 4'd3;
  localparam logic [3:0] T_S = 4'd4;
  localparam logic [3:0] T_Z = 4'd5;
  localparam logic [3:0] T_L = 4'd7;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       clear = 1'b0;
  logic       spawn_req = 1'b0;
  logic       hold_req = 1'b0;
  logic [3:0] queue_front = 4'd0;

  logic       pr   [2];
  logic [3:0] at   [2];
  logic       av   [2];
  logic [3:0] ht   [2];
  logic       hu   [2];
  logic       sd   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piece_spawner #(.HOLD_ENABLE(1'b1)) u_dut_hold (
    .clk(clk), .rst_l(rst_l), .clear(clear), .spawn_req(spawn_req),
    .hold_req(hold_req), .queue_front(queue_front),
    .pieces_remove(pr[0]), .active_type(at[0]), .active_valid(av[0]),
    .hold_type(ht[0]), .hold_used(hu[0]), .spawn_done(sd[0])
  );

  piece_spawner #(.HOLD_ENABLE(1'b0)) u_dut_nohold (
    .clk(clk), .rst_l(rst_l), .clear(clear), .spawn_req(spawn_req),
    .hold_req(hold_req), .queue_front(queue_front),
    .pieces_remove(pr[1]), .active_type(at[1]), .active_valid(av[1]),
    .hold_type(ht[1]), .hold_used(hu[1]), .spawn_done(sd[1])
  );

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a piece is either waiting on the queue, just captured
  // (pop pending), in play, or absent.
  logic [3:0] m_act   [2] = '{4'd0, 4'd0};
  logic [3:0] m_hold  [2] = '{4'd0, 4'd0};
  bit         m_used  [2] = '{1'b0, 1'b0};
  bit         m_wait  [2] = '{1'b0, 1'b0};
  bit         m_popn  [2] = '{1'b0, 1'b0};
  bit         m_play  [2] = '{1'b0, 1'b0};
  bit         m_sd    [2] = '{1'b0, 1'b0};

  task automatic model_clear(input int k);
    m_act[k] = T_BLANK; m_hold[k] = T_BLANK; m_used[k] = 0;
    m_wait[k] = 0; m_popn[k] = 0; m_play[k] = 0; m_sd[k] = 0;
  endtask

  task automatic model_step(input int k, input bit cl, input bit sp, input bit ho,
                            input logic [3:0] fr);
    bit just_popped;
    logic [3:0] tmp;
    if (cl) begin
      model_clear(k);
      return;
    end
    just_popped = m_popn[k];
    m_popn[k] = 0;
    m_sd[k] = 0;
    if (m_wait[k]) begin
      if (fr != T_BLANK) begin
        m_act[k] = fr; m_wait[k] = 0; m_popn[k] = 1;
      end
    end else if (just_popped) begin
      m_play[k] = 1; m_sd[k] = 1;
    end else if (m_play[k]) begin
      if (sp) begin
        m_play[k] = 0; m_wait[k] = 1; m_used[k] = 0;
      end else if (ho && k == 0 && !m_used[k]) begin
        m_used[k] = 1;
        if (m_hold[k] == T_BLANK) begin
          m_hold[k] = m_act[k]; m_play[k] = 0; m_wait[k] = 1;
        end else begin
          tmp = m_hold[k]; m_hold[k] = m_act[k]; m_act[k] = tmp; m_sd[k] = 1;
        end
      end
    end else if (sp) begin
      m_wait[k] = 1; m_used[k] = 0;
    end
  endtask

  // Single compare process: advance the model at each edge, check just after it.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_l) model_clear(k);
      else model_step(k, clear, spawn_req, hold_req, queue_front);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.pieces_remove", k), int'(pr[k]), int'(m_popn[k]));
      chk($sformatf("m%0d.active_type", k),   int'(at[k]), int'(m_act[k]));
      chk($sformatf("m%0d.active_valid", k),  int'(av[k]), int'(m_play[k]));
      chk($sformatf("m%0d.hold_type", k),     int'(ht[k]), int'(m_hold[k]));
      chk($sformatf("m%0d.hold_used", k),     int'(hu[k]), int'(m_used[k]));
      chk($sformatf("m%0d.spawn_done", k),    int'(sd[k]), int'(m_sd[k]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  int pops;

  initial begin
    // Reset.
    repeat (3) cyc();
    chk("rst.active_type", int'(at[0]), 0);
    chk("rst.active_valid", int'(av[0]), 0);
    chk("rst.pieces_remove", int'(pr[0]), 0);
    rst_l = 1'b1;
    cyc();

    // Reset then spawn: pop at cycle 2, active at cycle 3.
    queue_front = T_T; spawn_req = 1'b1; cyc(); spawn_req = 1'b0;
    chk("spawn.c1.pieces_remove", int'(pr[0]), 0);
    chk("spawn.c1.active_valid", int'(av[0]), 0);
    cyc();
    chk("spawn.c2.pieces_remove", int'(pr[0]), 1);
    chk("spawn.c2.active_type", int'(at[0]), int'(T_T));
    cyc();
    chk("spawn.c3.spawn_done", int'(sd[0]), 1);
    chk("spawn.c3.active_valid", int'(av[0]), 1);
    chk("spawn.c3.pieces_remove", int'(pr[0]), 0);
    chk("spawn.c3.hold_type", int'(ht[0]), int'(T_BLANK));

    // First hold: T goes to the slot, Z is fetched.
    queue_front = T_Z; hold_req = 1'b1; cyc(); hold_req = 1'b0;
    chk("hold1.hold_type", int'(ht[0]), int'(T_T));
    chk("hold1.active_valid", int'(av[0]), 0);
    chk("hold1.hold_used", int'(hu[0]), 1);
    chk("hold1.nohold_type", int'(ht[1]), int'(T_BLANK));
    chk("hold1.nohold_valid", int'(av[1]), 1);
    cyc();
    chk("hold1.pop", int'(pr[0]), 1);
    chk("hold1.active_type", int'(at[0]), int'(T_Z));
    cyc();
    chk("hold1.spawn_done", int'(sd[0]), 1);
    chk("hold1.hold_used_kept", int'(hu[0]), 1);

    // Second hold on the same piece is ignored.
    hold_req = 1'b1; cyc(); hold_req = 1'b0;
    chk("hold2.active_type", int'(at[0]), int'(T_Z));
    chk("hold2.hold_type", int'(ht[0]), int'(T_T));
    chk("hold2.spawn_done", int'(sd[0]), 0);

    // Spawn L, then swap with the held T.
    queue_front = T_L; spawn_req = 1'b1; cyc(); spawn_req = 1'b0;
    chk("spawnL.hold_used", int'(hu[0]), 0);
    cyc(); cyc();
    chk("spawnL.active_type", int'(at[0]), int'(T_L));
    hold_req = 1'b1; cyc(); hold_req = 1'b0;
    chk("swap.active_type", int'(at[0]), int'(T_T));
    chk("swap.hold_type", int'(ht[0]), int'(T_L));
    chk("swap.spawn_done", int'(sd[0]), 1);
    chk("swap.pieces_remove", int'(pr[0]), 0);
    chk("swap.active_valid", int'(av[0]), 1);

    // Simultaneous spawn and hold: spawn wins.
    queue_front = T_O; spawn_req = 1'b1; hold_req = 1'b1; cyc();
    spawn_req = 1'b0; hold_req = 1'b0;
    chk("simul.hold_type", int'(ht[0]), int'(T_L));
    chk("simul.hold_used", int'(hu[0]), 0);
    chk("simul.active_valid", int'(av[0]), 0);
    cyc(); cyc();
    chk("simul.active_type", int'(at[0]), int'(T_O));

    // Blank queue stall for five cycles, then I.
    queue_front = T_BLANK; spawn_req = 1'b1; cyc(); spawn_req = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (pr[0]) pops++;
      cyc();
    end
    chk("stall.no_pop", pops, 0);
    queue_front = T_I; cyc();
    chk("stall.pop", int'(pr[0]), 1);
    chk("stall.active_type", int'(at[0]), int'(T_I));
    cyc();
    chk("stall.spawn_done", int'(sd[0]), 1);
    chk("stall.no_second_pop", int'(pr[0]), 0);

    // Clear during the fetch-capture cycle.
    queue_front = T_S; spawn_req = 1'b1; cyc(); spawn_req = 1'b0;
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear.active_type", int'(at[0]), int'(T_BLANK));
    chk("clear.hold_type", int'(ht[0]), int'(T_BLANK));
    chk("clear.pieces_remove", int'(pr[0]), 0);
    chk("clear.active_valid", int'(av[0]), 0);
    cyc();
    chk("clear.idle_no_pop", int'(pr[0]), 0);

    // Random traffic, checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      spawn_req   = ($urandom_range(0, 7) == 0);
      hold_req    = ($urandom_range(0, 4) == 0);
      clear       = ($urandom_range(0, 99) == 0);
      queue_front = ($urandom_range(0, 2) == 0) ? T_BLANK : 4'($urandom_range(1, 7));
      cyc();
    end
    spawn_req = 1'b0; hold_req = 1'b0; clear = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piece_spawner.md
# piece_spawner

Downstream consumer of the next-piece queue. It pops the front tetromino from the queue to become the active falling piece and drives the queue's `pieces_remove` strobe. It also implements the Guideline hold slot, including the one-hold-per-piece lockout. It sits between the seven-bag queue and the game-state FSM and the falling-piece logic.

## Interface
- `HOLD_ENABLE`, default 1: when 0, `hold_req` is ignored and `hold_type` stays BLANK.

Ports (all tile ports are `tile_type_t`, 4 bits):
- `clk`  in  1  system clock.
- `rst_l`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous game restart; highest priority.
- `spawn_req`  in  1  one-cycle pulse from the game FSM: previous piece locked, new piece needed.
- `hold_req`  in  1  one-cycle pulse from the input controller: player pressed hold.
- `queue_front`  in  4  head of the next-piece queue (`pieces_queue[0]`); BLANK means not ready.
- `pieces_remove`  out  1  pop strobe to the queue; high exactly one cycle per pop.
- `active_type`  out  4  current falling piece type.
- `active_valid`  out  1  high while the state is ACTIVE.
- `hold_type`  out  4  held piece; BLANK if the slot is empty.
- `hold_used`  out  1  hold already used for the current piece.
- `spawn_done`  out  1  one-cycle pulse: new `active_type` is valid and the piece should be placed at the spawn location.

## Operation
Reset values (`rst_l` low, or `clear` at a clock edge): state IDLE, `active_type`=BLANK, `hold_type`=BLANK, `active_valid`=0, `hold_used`=0, `pieces_remove`=0, `spawn_done`=0. An asynchronous reset mid-operation aborts any fetch; no pop is issued.

States and transitions:
- IDLE
  - `spawn_req` → FETCH with `hold_used`←0.
  - `hold_req` is ignored.
- FETCH
  - `queue_front`≠BLANK: capture `active_type`←`queue_front`, then → POP.
  - `queue_front`=BLANK: stay in FETCH indefinitely.
  - `spawn_req` and `hold_req` are ignored.
- POP
  - `pieces_remove`=1 (Moore output) for exactly this cycle, then → ACTIVE.
  - `spawn_done` is registered high for the first ACTIVE cycle.
  - The capture cycle and the pop cycle are distinct. The queue head therefore shifts only after capture, so a single fetch cannot double-pop or double-capture.
- ACTIVE
  - `spawn_req` → FETCH, `hold_used`←0, `active_valid` drops.
  - `hold_req`, with `HOLD_ENABLE`=1 and `hold_used`=0:
    - `hold_type`=BLANK: `hold_type`←`active_type`, `hold_used`←1, → FETCH. The fetch does not clear `hold_used`.
    - `hold_type`≠BLANK: swap `active_type`↔`hold_type`, `hold_used`←1, stay in ACTIVE, pulse `spawn_done` next cycle. No pop is issued.
  - `hold_req` with `hold_used`=1: ignored.
  - `spawn_req` and `hold_req` in the same cycle: `spawn_req` wins and the hold is dropped.

Other rules:
- `clear` overrides all requests in every state, including a pending POP; `pieces_remove` is not asserted.
- Only FETCH samples `queue_front`.
- `active_type` changes only on a FETCH capture, a swap, or reset/clear.

## Timing
- Spawn latency, front ready: `spawn_req` at cycle 0 → FETCH cycle 1 (capture) → POP cycle 2 (`pieces_remove`=1) → ACTIVE cycle 3 with `spawn_done`=1 and `active_valid`=1.
- Each cycle that `queue_front` is BLANK in FETCH adds one cycle to that latency.
- Swap latency: `hold_req` at cycle 0 → cycle 1 shows swapped `active_type`/`hold_type`, `spawn_done`=1, `active_valid` remains 1.
- First-hold latency: `hold_req` at cycle 0 → cycle 1 `hold_type` updated, `active_valid`=0, state FETCH → same as spawn from there (ACTIVE at cycle 3 if front ready).
- `pieces_remove` has no combinational path from any input.
- All outputs are registered or decoded from state only.

## Test plan
- **Reset then spawn.** Reset, `queue_front`=T, `spawn_req` at cycle 0 → `pieces_remove`=1 only at cycle 2; `active_type`=T, `spawn_done`=1, `active_valid`=1 at cycle 3; `hold_type`=BLANK.
- **Blank queue stall.** `queue_front`=BLANK for 5 cycles after `spawn_req`, then I → capture on the first non-BLANK cycle, a single `pieces_remove` pulse, `active_type`=I; no pop during the stall.
- **First hold.** ACTIVE with S, `hold_type`=BLANK, front=Z, `hold_req` → `hold_type`=S, `active_type`=Z after fetch, exactly one pop, `hold_used`=1; a second `hold_req` → no change.
- **Swap.** ACTIVE with L, `hold_type`=O, `hold_used`=0, `hold_req` → next cycle `active_type`=O, `hold_type`=L, `spawn_done`=1, `pieces_remove` stays 0; next `spawn_req` clears `hold_used`.
- **Simultaneous requests.** `spawn_req` and `hold_req` in the same ACTIVE cycle → normal spawn; `hold_type` unchanged, `hold_used`=0.
- **Clear mid-pop.** `clear` asserted in the FETCH-capture cycle → next cycle IDLE, all outputs at reset values, `pieces_remove` never asserted. `HOLD_ENABLE`=0 variant: `hold_req` never changes any output.
